sid_voice_mixer: RTL

Time-multiplexed mixing stage directly downstream of the three `sid_voice_8580` instances. Per `ce_1m` tick it snapshots the three signed voice outputs, splits them into filter-routed and direct sums, and hands the routed sum to the filter. It then combines the filter's return with the direct sum, applies master volume and saturates to a signed 16-bit sample. A one-cycle valid strobe accompanies each sample.

---
 rtl/sid_mixer_pkg.sv | 24 ++
 rtl/sid_mixer_sat.sv | 22 ++
 rtl/sid_voice_mixer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sid_mixer_pkg.sv
// Shared types and constants for the SID voice mixer.
package sid_mixer_pkg;

  localparam int unsigned ACC_W_DEFAULT = 18;
  localparam int unsigned OUT_W_DEFAULT = 16;
  localparam int unsigned VOICE_W       = 12;
  localparam int unsigned VOL_W         = 4;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef enum logic [3:0] {
    StIdle,
    StSumV1,
    StSumV2,
    StSumV3,
    StSumExt,
    StRoute,
    StWaitFilt,
    StMix,
    StScale
  } mix_state_e;

endpackage

// File: rtl/sid_mixer_sat.sv
// Signed saturating narrower: clamps a wide two's-complement value into OUT_W bits.
module sid_mixer_sat #(
  parameter int unsigned IN_W  = 21,
  parameter int unsigned OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  in_i,
  output logic signed [OUT_W-1:0] out_o
);

  // Bits from the output sign position upward must all agree for the value to fit.
  logic [IN_W-OUT_W:0] top_bits;
  assign top_bits = in_i[IN_W-1:OUT_W-1];

  // Pass through when in range, otherwise clamp toward the sign of the input.
  always_comb begin
    out_o = in_i[OUT_W-1:0];
    if (!((&top_bits) || !(|top_bits))) begin
      out_o = in_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/sid_voice_mixer.sv
// Time-multiplexed SID voice mixer: routes voices to the filter, recombines the
// filter return with the direct path, applies master volume and saturates.
// Optional external input enabled by defining SID_MIXER_EXT_IN_EN.
module sid_voice_mixer
  import sid_mixer_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEFAULT,
  parameter int unsigned OUT_W = OUT_W_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ce_1m,
  input  logic signed [VOICE_W-1:0] voice1,
  input  logic signed [VOICE_W-1:0] voice2,
  input  logic signed [VOICE_W-1:0] voice3,
  input  logic [7:0]                res_filt,
  input  logic [7:0]                mode_vol,
`ifdef SID_MIXER_EXT_IN_EN
  input  logic signed [VOICE_W-1:0] ext_in,
`endif
  output logic signed [OUT_W-1:0]   filt_in,
  output logic                      filt_in_valid,
  input  logic signed [OUT_W-1:0]   filt_out,
  input  logic                      filt_done,
  output logic signed [OUT_W-1:0]   audio_out,
  output logic                      audio_valid,
  output logic                      overrun,
  output logic                      busy
);

  localparam int unsigned ProdW = ACC_W + VOL_W + 1;
  localparam int unsigned ScalW = ProdW - 2;

  mix_state_e state_q, state_d;

  logic signed [VOICE_W-1:0] v1_q, v2_q, v3_q;
  logic [3:0]                route_q;
  logic                      three_off_q;
  logic [VOL_W-1:0]          vol_q;
`ifdef SID_MIXER_EXT_IN_EN
  logic signed [VOICE_W-1:0] ext_q;
`endif

  logic signed [ACC_W-1:0] acc_f_q, acc_f_d, acc_d_q, acc_d_d;
  logic signed [OUT_W-1:0] fret_q, fret_d;

  logic signed [ACC_W-1:0] src;
  logic                    src_routed, src_en;

  logic signed [ACC_W-1:0] mix;
  logic signed [VOL_W:0]   vol_s;
  logic signed [ProdW-1:0] prod;
  logic signed [ScalW-1:0] scaled;
  logic signed [OUT_W-1:0] sat_val;

  logic signed [OUT_W-1:0] filt_in_q, audio_out_q;
  logic                    filt_in_valid_q, audio_valid_q, overrun_q, busy_q;

`ifdef SID_MIXER_EXT_IN_EN
  logic [6:0] unused_bits;
  assign unused_bits = {res_filt[7:4], mode_vol[6:4]};
`else
  logic [7:0] unused_bits;
  assign unused_bits = {res_filt[7:3], mode_vol[6:4]};
`endif

  // Sequencer: one source per SUM state, then filter handshake, mix and scale.
  always_comb begin
    state_d    = state_q;
    acc_f_d    = acc_f_q;
    acc_d_d    = acc_d_q;
    fret_d     = fret_q;
    src        = '0;
    src_routed = 1'b0;
    src_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ce_1m) begin
          acc_f_d = '0;
          acc_d_d = '0;
          state_d = StSumV1;
        end
      end
      StSumV1: begin
        src        = {{(ACC_W-VOICE_W){v1_q[VOICE_W-1]}}, v1_q};
        src_routed = route_q[0];
        src_en     = 1'b1;
        state_d    = StSumV2;
      end
      StSumV2: begin
        src        = {{(ACC_W-VOICE_W){v2_q[VOICE_W-1]}}, v2_q};
        src_routed = route_q[1];
        src_en     = 1'b1;
        state_d    = StSumV3;
      end
      StSumV3: begin
        src        = {{(ACC_W-VOICE_W){v3_q[VOICE_W-1]}}, v3_q};
        src_routed = route_q[2];
        // 3OFF only mutes voice 3 on the direct path.
        src_en     = route_q[2] | ~three_off_q;
        state_d    = StSumExt;
      end
      StSumExt: begin
`ifdef SID_MIXER_EXT_IN_EN
        src        = {{(ACC_W-VOICE_W){ext_q[VOICE_W-1]}}, ext_q};
        src_routed = route_q[3];
        src_en     = 1'b1;
`endif
        state_d    = StRoute;
      end
      StRoute: state_d = StWaitFilt;
      StWaitFilt: begin
        if (filt_done) begin
          fret_d  = filt_out;
          state_d = StMix;
        end else if (ce_1m) begin
          // A new tick forces the pending sample out with a silent filter return.
          fret_d  = '0;
          state_d = StMix;
        end
      end
      StMix:   state_d = StScale;
      StScale: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (src_en) begin
      if (src_routed) acc_f_d = acc_f_q + src;
      else            acc_d_d = acc_d_q + src;
    end
  end

  // Mix and volume datapath, evaluated while in MIX so the result registers on entry to SCALE.
  always_comb begin
    mix    = acc_d_q + {{(ACC_W-OUT_W){fret_q[OUT_W-1]}}, fret_q};
    vol_s  = {1'b0, vol_q};
    prod   = ProdW'(mix) * ProdW'(vol_s);
    scaled = prod[ProdW-1:2];
  end

  sid_mixer_sat #(
    .IN_W  (ScalW),
    .OUT_W (OUT_W)
  ) u_sat (
    .in_i  (scaled),
    .out_o (sat_val)
  );

  // State, snapshot and registered-output update with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= StIdle;
      v1_q            <= '0;
      v2_q            <= '0;
      v3_q            <= '0;
      route_q         <= '0;
      three_off_q     <= 1'b0;
      vol_q           <= '0;
`ifdef SID_MIXER_EXT_IN_EN
      ext_q           <= '0;
`endif
      acc_f_q         <= '0;
      acc_d_q         <= '0;
      fret_q          <= '0;
      filt_in_q       <= '0;
      filt_in_valid_q <= 1'b0;
      audio_out_q     <= '0;
      audio_valid_q   <= 1'b0;
      overrun_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_f_q <= acc_f_d;
      acc_d_q <= acc_d_d;
      fret_q  <= fret_d;
      if (state_q == StIdle && ce_1m) begin
        v1_q        <= voice1;
        v2_q        <= voice2;
        v3_q        <= voice3;
        route_q     <= res_filt[3:0];
        three_off_q <= mode_vol[7];
        vol_q       <= mode_vol[VOL_W-1:0];
`ifdef SID_MIXER_EXT_IN_EN
        ext_q       <= ext_in;
`endif
      end
      // Present the routed sum for the whole ROUTE cycle.
      filt_in_valid_q <= (state_q == StSumExt);
      if (state_q == StSumExt) filt_in_q <= acc_f_d[OUT_W-1:0];
      audio_valid_q <= (state_q == StMix);
      if (state_q == StMix) audio_out_q <= sat_val;
      overrun_q <= ce_1m && (state_q != StIdle);
      busy_q    <= (state_d != StIdle);
    end
  end

  assign filt_in       = filt_in_q;
  assign filt_in_valid = filt_in_valid_q;
  assign audio_out     = audio_out_q;
  assign audio_valid   = audio_valid_q;
  assign overrun       = overrun_q;
  assign busy          = busy_q;

endmodule
